fp16_dot_feeder: RTL and testbench

- Upstream operand sequencer for the half-precision dot-product MAC.
- Holds two FP16 vectors A and B in small register buffers, loaded through a simple write port.
- On go83, streams element pairs into the MAC using its start/done handshake, one pair per MAC transaction.
- Captures the MAC answer after the last pair, presents it with a one-cycle valid pulse, and flags length errors and MAC timeouts.

---
 rtl/fp16_pkg.sv | 21 ++
 rtl/fp16_dot_feeder_if.sv | 34 +++
 rtl/fp16_vec_buf.sv | 25 ++
 rtl/fp16_dot_feeder.sv | 138 +++++++++++++
 tb/tb_fp16_dot_feeder.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 constants and the dot-product feeder state encoding.
package fp16_pkg;

  localparam int unsigned FP16_SIGN_W = 1;
  localparam int unsigned FP16_EXP_W  = 5;
  localparam int unsigned FP16_MAN_W  = 10;
  localparam int unsigned FP16_W      = FP16_SIGN_W + FP16_EXP_W + FP16_MAN_W;
  localparam int unsigned FP16_BIAS   = 15;

  localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitHi,
    StWaitLo,
    StFinish
  } feeder_state_e;

endpackage

// File: rtl/fp16_dot_feeder_if.sv
// Host write/go/result signals plus the MAC start/done handshake of the feeder.
interface fp16_dot_feeder_if
  import fp16_pkg::*;
#(
  parameter int unsigned AW = 4
);
  logic              wr_en83;
  logic              wr_sel83;
  logic [AW-1:0]     wr_addr83;
  logic [FP16_W-1:0] wr_data83;
  logic [AW:0]       len83;
  logic              go83;
  logic              busy83;
  logic              mac_start83;
  logic [FP16_W-1:0] mac_a83;
  logic [FP16_W-1:0] mac_b83;
  logic              mac_done83;
  logic [FP16_W-1:0] mac_ans83;
  logic [FP16_W-1:0] result83;
  logic              result_valid83;
  logic              err83;

  // Master is the host and MAC side; slave is the feeder.
  modport master (
    output wr_en83, wr_sel83, wr_addr83, wr_data83, len83, go83, mac_done83, mac_ans83,
    input  busy83, mac_start83, mac_a83, mac_b83, result83, result_valid83, err83
  );

  modport slave (
    input  wr_en83, wr_sel83, wr_addr83, wr_data83, len83, go83, mac_done83, mac_ans83,
    output busy83, mac_start83, mac_a83, mac_b83, result83, result_valid83, err83
  );

endinterface

// File: rtl/fp16_vec_buf.sv
// DEPTH x FP16 register array: one synchronous write port, one combinational read port.
module fp16_vec_buf
  import fp16_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [FP16_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [FP16_W-1:0] o_rdata
);

  logic [FP16_W-1:0] r_mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fp16_dot_feeder.sv
// Streams A/B element pairs into the FP16 MAC one transaction at a time and
// returns the final MAC answer; flags bad lengths and MAC watchdog timeouts.
module fp16_dot_feeder
  import fp16_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic               clk83,
  input logic               reset83,
  fp16_dot_feeder_if.slave  bus
);

  localparam int unsigned    WdW    = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]    LenMax = (AW + 1)'(DEPTH);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  feeder_state_e     r_state;
  logic [AW:0]       r_idx, r_len_q;
  logic [WdW-1:0]    r_wdog;
  logic [FP16_W-1:0] r_hold, r_mac_a, r_mac_b, r_result;
  logic              r_busy, r_start, r_valid, r_err;

  logic              w_wr_ok, w_we_a, w_we_b, w_len_bad, w_last;
  logic [AW:0]       w_idx_nxt;
  logic [FP16_W-1:0] w_rd_a, w_rd_b;

  // Buffers only accept writes while idle so a run sees a frozen snapshot.
  assign w_wr_ok   = bus.wr_en83 && (r_state == StIdle) && !reset83;
  assign w_we_a    = w_wr_ok && !bus.wr_sel83;
  assign w_we_b    = w_wr_ok && bus.wr_sel83;
  assign w_len_bad = (bus.len83 == '0) || (bus.len83 > LenMax);
  assign w_last    = (r_idx == r_len_q - 1'b1);
  assign w_idx_nxt = r_idx + 1'b1;

  fp16_vec_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf_a (
    .i_clk   (clk83),
    .i_we    (w_we_a),
    .i_waddr (bus.wr_addr83),
    .i_wdata (bus.wr_data83),
    .i_raddr (r_idx[AW-1:0]),
    .o_rdata (w_rd_a)
  );

  fp16_vec_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf_b (
    .i_clk   (clk83),
    .i_we    (w_we_b),
    .i_waddr (bus.wr_addr83),
    .i_wdata (bus.wr_data83),
    .i_raddr (r_idx[AW-1:0]),
    .o_rdata (w_rd_b)
  );

  always_ff @(posedge clk83) begin
    if (reset83) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_len_q  <= '0;
      r_wdog   <= '0;
      r_hold   <= FP16_ZERO;
      r_mac_a  <= FP16_ZERO;
      r_mac_b  <= FP16_ZERO;
      r_result <= FP16_ZERO;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        StIdle: begin
          r_busy <= 1'b0;
          if (bus.go83) begin
            if (w_len_bad) begin
              r_err <= 1'b1;
            end else begin
              r_state <= StIssue;
              r_len_q <= bus.len83;
              r_idx   <= '0;
              r_busy  <= 1'b1;
            end
          end
        end
        StIssue: begin
          r_mac_a <= w_rd_a;
          r_mac_b <= w_rd_b;
          r_start <= 1'b1;
          r_wdog  <= '0;
          r_state <= StWaitHi;
        end
        StWaitHi: begin
          if (bus.mac_done83) begin
            r_start <= 1'b0;
            r_wdog  <= '0;
            r_state <= StWaitLo;
            if (w_last) r_hold <= bus.mac_ans83;
          end else if (r_wdog == WdLast) begin
            // Abort leaves busy high for the error cycle; idle clears it next.
            r_start <= 1'b0;
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        StWaitLo: begin
          if (!bus.mac_done83) begin
            r_idx   <= w_idx_nxt;
            r_state <= (w_idx_nxt == r_len_q) ? StFinish : StIssue;
          end else if (r_wdog == WdLast) begin
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        StFinish: begin
          r_result <= r_hold;
          r_valid  <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy83         = r_busy;
  assign bus.mac_start83    = r_start;
  assign bus.mac_a83        = r_mac_a;
  assign bus.mac_b83        = r_mac_b;
  assign bus.result83       = r_result;
  assign bus.result_valid83 = r_valid;
  assign bus.err83          = r_err;

endmodule

// File: tb/tb_fp16_dot_feeder.sv
// Scoreboard bench: stimulus queues expected operand pairs and result/error
// events; a negedge monitor pops and compares; a MAC model answers the handshake.
module tb_fp16_dot_feeder;
  import fp16_pkg::*;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned TIMEOUT = 64;

  typedef struct {
    bit          is_err;
    bit          busy;
    logic [15:0] val;
  } evt_t;

  logic clk83   = 1'b0;
  logic reset83 = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  logic [31:0] exp_pair[$];
  evt_t        exp_evt[$];
  logic [15:0] ans_q[$];
  logic [15:0] ref_a [DEPTH];
  logic [15:0] ref_b [DEPTH];
  logic [15:0] exp_result = 16'h0000;
  evt_t        mon_e;
  logic        prev_start = 1'b0;
  bit          hang       = 1'b0;
  int          fixed_dly  = 4;
  int          cnt        = 0;
  int          dly        = 4;

  fp16_dot_feeder_if #(.AW(AW)) bus ();

  fp16_dot_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk83   (clk83),
    .reset83 (reset83),
    .bus     (bus)
  );

  always #5 clk83 = ~clk83;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // MAC model: done rises dly cycles into a start, falls once start drops.
  always @(negedge clk83) begin
    if (reset83) begin
      bus.mac_done83 = 1'b0;
      bus.mac_ans83  = 16'h0000;
      cnt = 0;
    end else if (bus.mac_done83) begin
      if (!bus.mac_start83) begin
        bus.mac_done83 = 1'b0;
        bus.mac_ans83  = 16'($urandom);
      end
    end else if (bus.mac_start83 && !hang) begin
      if (cnt == 0) dly = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 5));
      cnt++;
      if (cnt >= dly) begin
        bus.mac_done83 = 1'b1;
        bus.mac_ans83  = (ans_q.size() != 0) ? ans_q.pop_front() : 16'hDEAD;
        cnt = 0;
      end
    end
  end

  // Monitor.
  always @(negedge clk83) begin
    if (!reset83) begin
      if (bus.mac_start83 && !prev_start) begin
        check("pair_avail", 32'(exp_pair.size() != 0), 32'd1);
        if (exp_pair.size() != 0) check("operands", {bus.mac_a83, bus.mac_b83}, exp_pair.pop_front());
      end
      if (bus.result_valid83 || bus.err83) begin
        check("evt_avail", 32'(exp_evt.size() != 0), 32'd1);
        if (exp_evt.size() != 0) begin
          mon_e = exp_evt.pop_front();
          check("evt_err", 32'(bus.err83), 32'(mon_e.is_err));
          check("evt_valid", 32'(bus.result_valid83), 32'(!mon_e.is_err));
          check("evt_busy", 32'(bus.busy83), 32'(mon_e.busy));
          if (!mon_e.is_err) check("result", 32'(bus.result83), 32'(mon_e.val));
        end
      end
      prev_start = bus.mac_start83;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic wr(input bit sel, input int addr, input logic [15:0] data, input bit upd);
    @(negedge clk83);
    bus.wr_en83   = 1'b1;
    bus.wr_sel83  = sel;
    bus.wr_addr83 = AW'(addr);
    bus.wr_data83 = data;
    @(negedge clk83);
    bus.wr_en83 = 1'b0;
    if (upd) begin
      if (sel) ref_b[addr] = data;
      else ref_a[addr] = data;
    end
  endtask

  task automatic launch(input int len, input logic [15:0] last_ans);
    if (len == 0 || len > int'(DEPTH)) begin
      exp_evt.push_back('{1'b1, 1'b0, 16'h0000});
    end else begin
      for (int i = 0; i < len; i++) begin
        exp_pair.push_back({ref_a[i], ref_b[i]});
        if (hang) break;
        ans_q.push_back((i == len - 1) ? last_ans : 16'($urandom));
      end
      if (hang) exp_evt.push_back('{1'b1, 1'b1, 16'h0000});
      else begin
        exp_evt.push_back('{1'b0, 1'b0, last_ans});
        exp_result = last_ans;
      end
    end
    @(negedge clk83);
    bus.go83  = 1'b1;
    bus.len83 = (AW + 1)'(len);
    @(negedge clk83);
    bus.go83 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while ((exp_pair.size() != 0 || exp_evt.size() != 0 || bus.busy83) && c < 4000) begin
      @(negedge clk83);
      c++;
    end
    check({name, "_drained"}, 32'(exp_pair.size() + exp_evt.size()), 32'd0);
    @(negedge clk83);
    check({name, "_busy_low"}, 32'(bus.busy83), 32'd0);
    check({name, "_result_hold"}, 32'(bus.result83), 32'(exp_result));
    exp_pair.delete();
    exp_evt.delete();
    ans_q.delete();
  endtask

  task automatic wait_start_rise();
    int c = 0;
    while (!bus.mac_start83 && c < 50) begin
      @(negedge clk83);
      c++;
    end
    check("start_seen", 32'(bus.mac_start83), 32'd1);
  endtask

  initial begin
    int n;
    int rises;
    logic ps;
    bus.wr_en83   = 1'b0;
    bus.wr_sel83  = 1'b0;
    bus.wr_addr83 = '0;
    bus.wr_data83 = 16'h0000;
    bus.len83     = '0;
    bus.go83      = 1'b0;
    repeat (3) @(negedge clk83);
    check("rst_busy", 32'(bus.busy83), 32'd0);
    check("rst_start", 32'(bus.mac_start83), 32'd0);
    check("rst_valid", 32'(bus.result_valid83), 32'd0);
    check("rst_err", 32'(bus.err83), 32'd0);
    check("rst_mac_a", 32'(bus.mac_a83), 32'(FP16_ZERO));
    check("rst_mac_b", 32'(bus.mac_b83), 32'(FP16_ZERO));
    check("rst_result", 32'(bus.result83), 32'(FP16_ZERO));
    reset83 = 1'b0;

    // Basic two-pair run.
    wr(1'b0, 0, 16'h3C00, 1'b1);
    wr(1'b0, 1, 16'h4000, 1'b1);
    wr(1'b1, 0, 16'h4000, 1'b1);
    wr(1'b1, 1, 16'h3800, 1'b1);
    launch(2, 16'h4200);
    wait_idle("basic");

    // Bad lengths.
    launch(0, 16'h0000);
    check("len0_busy", 32'(bus.busy83), 32'd0);
    wait_idle("len0");
    launch(17, 16'h0000);
    check("len17_busy", 32'(bus.busy83), 32'd0);
    wait_idle("len17");

    // Full depth.
    for (int i = 0; i < int'(DEPTH); i++) begin
      wr(1'b0, i, FP16_ONE, 1'b1);
      wr(1'b1, i, FP16_ONE, 1'b1);
    end
    launch(16, 16'($urandom));
    wait_idle("full");

    // Frozen buffers during a run, then the same write lands when idle.
    launch(2, 16'($urandom));
    wait_start_rise();
    wr(1'b0, 0, 16'h4400, 1'b0);
    wait_idle("frozen");
    wr(1'b0, 0, 16'h4400, 1'b1);
    launch(2, 16'($urandom));
    wait_idle("thawed");

    // MAC never answers.
    hang = 1'b1;
    launch(2, 16'h0000);
    wait_start_rise();
    n = 0;
    while (bus.mac_start83 && n < 200) begin
      n++;
      @(negedge clk83);
    end
    check("timeout_start_cycles", 32'(n), 32'(TIMEOUT));
    hang = 1'b0;
    wait_idle("timeout");

    // Randomized runs.
    fixed_dly = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        wr(1'b0, i, 16'($urandom), 1'b1);
        wr(1'b1, i, 16'($urandom), 1'b1);
      end
      launch(int'($urandom_range(1, DEPTH)), 16'($urandom));
      wait_idle("random");
    end

    // Reset while waiting on pair 1.
    fixed_dly = 4;
    launch(3, 16'($urandom));
    rises = 0;
    ps    = 1'b0;
    n     = 0;
    while (rises < 2 && n < 200) begin
      @(negedge clk83);
      if (bus.mac_start83 && !ps) rises++;
      ps = bus.mac_start83;
      n++;
    end
    check("midrun_pair1_seen", 32'(rises), 32'd2);
    reset83 = 1'b1;
    @(negedge clk83);
    check("midrun_start", 32'(bus.mac_start83), 32'd0);
    check("midrun_busy", 32'(bus.busy83), 32'd0);
    check("midrun_valid", 32'(bus.result_valid83), 32'd0);
    check("midrun_err", 32'(bus.err83), 32'd0);
    reset83 = 1'b0;
    exp_pair.delete();
    exp_evt.delete();
    ans_q.delete();
    exp_result = 16'h0000;
    launch(2, 16'($urandom));
    wait_idle("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

endmodule
